output_action_demux: RTL and testbench

//  Parametrised successor to the 5-port output action stage: takes one action stream whose tuser[NUM_QUEUES-1:0] is
//  a destination bitmap and fans each beat into per-destination FIFOs (atomic multicast). Adds real backpressure,

---
 rtl/output_action_pkg.sv | 19 +
 rtl/action_queue_fifo.sv | 82 ++++++++
 rtl/output_action_demux.sv | 119 +++++++++++
 tb/tb_output_action_demux.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_action_pkg.sv
// Shared sizing helpers for the output action demux: counter width default,
// FIFO depth / occupancy width and flattened-bus slice arithmetic.
package output_action_pkg;

    localparam int CNT_W_DEFAULT = 32;

    function automatic int fifo_depth(input int depth_bits);
        return 1 << depth_bits;
    endfunction

    function automatic int level_width(input int depth_bits);
        return depth_bits + 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/action_queue_fifo.sv
// Single fall-through FIFO: head entry is visible combinationally while non-empty;
// full/empty/level are registered and a write to a full queue is always refused.
module action_queue_fifo
    import output_action_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_BITS:0]   o_level
);

    localparam int                  DEPTH    = fifo_depth(DEPTH_BITS);
    localparam logic [DEPTH_BITS:0] FULL_LVL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] LVL_ONE  = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  w_wr;
    logic                  w_rd;
    logic [DEPTH_BITS:0]   w_level_nxt;

    // Full check uses the registered flag, so a same-cycle pop never frees a slot for a write.
    assign w_wr = i_wr_en & ~r_full;
    assign w_rd = i_rd_en & ~r_empty;

    // Next occupancy from the qualified write/read pair.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr, w_rd})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {DEPTH_BITS{1'b0}};
            r_rd_ptr <= {DEPTH_BITS{1'b0}};
            r_level  <= {(DEPTH_BITS + 1){1'b0}};
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == FULL_LVL);
            r_empty <= (w_level_nxt == {(DEPTH_BITS + 1){1'b0}});
        end
    end

    // Storage array; contents are don't-care until written so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = r_empty;
    assign o_full    = r_full;
    assign o_level   = r_level;

endmodule

// File: rtl/output_action_demux.sv
// Fans one action stream into NUM_QUEUES fall-through FIFOs using tuser[NUM_QUEUES-1:0] as a
// destination bitmap. Define OUTPUT_ACTION_DROP_ON_FULL_EN to drop copies to full queues instead of stalling.
module output_action_demux
    import output_action_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = CNT_W_DEFAULT,
    parameter int C_ACT_TDATA_WIDTH  = 256,
    parameter int C_ACT_TUSER_WIDTH  = 128,
    parameter int NUM_QUEUES         = 5,
    parameter int DEPTH_BITS         = 4
) (
    input  logic                                        axi_aclk,
    input  logic                                        axi_resetn,
    input  logic [C_ACT_TDATA_WIDTH-1:0]                s_axis_tdata,
    input  logic [C_ACT_TUSER_WIDTH-1:0]                s_axis_tuser,
    input  logic                                        s_axis_tvalid,
    output logic                                        s_axis_tready,
    output logic [NUM_QUEUES*C_ACT_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [NUM_QUEUES*C_ACT_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic [NUM_QUEUES-1:0]                       m_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                       m_axis_tready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               out_arb_counter,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               out_arb_rd_counter,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               out_drop_counter,
    output logic [NUM_QUEUES*(DEPTH_BITS+1)-1:0]        out_queue_level
);

    localparam int DW    = C_ACT_TDATA_WIDTH;
    localparam int UW    = C_ACT_TUSER_WIDTH;
    localparam int ENT_W = DW + UW;
    localparam int LVL_W = level_width(DEPTH_BITS);
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = C_S_AXI_DATA_WIDTH'(1);

    logic [NUM_QUEUES-1:0] w_dest;
    logic [NUM_QUEUES-1:0] w_full;
    logic [NUM_QUEUES-1:0] w_empty;
    logic [NUM_QUEUES-1:0] w_wr_en;
    logic [NUM_QUEUES-1:0] w_rd_en;
    logic [ENT_W-1:0]      w_head [NUM_QUEUES];
    logic                  w_accept;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_arb_cnt;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rd_cnt;

    assign w_dest   = s_axis_tuser[NUM_QUEUES-1:0];
    assign w_accept = s_axis_tvalid & s_axis_tready;
    assign w_rd_en  = m_axis_tvalid & m_axis_tready;

`ifdef OUTPUT_ACTION_DROP_ON_FULL_EN
    logic                          w_drop;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_drop_cnt;

    // Never stall: copies go to every targeted queue that has room, the rest are dropped.
    always_comb begin
        s_axis_tready = 1'b1;
        w_wr_en       = w_dest & ~w_full & {NUM_QUEUES{s_axis_tvalid}};
        w_drop        = s_axis_tvalid & (|(w_dest & w_full));
    end

    // Beats that lost at least one copy.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_drop_cnt <= {C_S_AXI_DATA_WIDTH{1'b0}};
        end else if (w_drop) begin
            r_drop_cnt <= r_drop_cnt + CNT_ONE;
        end
    end

    assign out_drop_counter = r_drop_cnt;
`else
    // Atomic multicast: stall unless every targeted queue can take the beat.
    always_comb begin
        s_axis_tready = ~(|(w_dest & w_full));
        w_wr_en       = w_dest & {NUM_QUEUES{s_axis_tvalid & s_axis_tready}};
    end

    assign out_drop_counter = {C_S_AXI_DATA_WIDTH{1'b0}};
`endif

    // Accepted-beat and read-cycle statistics; both wrap naturally.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_arb_cnt <= {C_S_AXI_DATA_WIDTH{1'b0}};
            r_rd_cnt  <= {C_S_AXI_DATA_WIDTH{1'b0}};
        end else begin
            if (w_accept && (|w_dest)) begin
                r_arb_cnt <= r_arb_cnt + CNT_ONE;
            end
            if (|w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + CNT_ONE;
            end
        end
    end

    assign out_arb_counter    = r_arb_cnt;
    assign out_arb_rd_counter = r_rd_cnt;
    assign m_axis_tvalid      = ~w_empty;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_queue
        action_queue_fifo #(
            .DATA_W     (ENT_W),
            .DEPTH_BITS (DEPTH_BITS)
        ) u_fifo (
            .clk       (axi_aclk),
            .rst_n     (axi_resetn),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_data ({s_axis_tdata, s_axis_tuser}),
            .i_rd_en   (w_rd_en[g]),
            .o_rd_data (w_head[g]),
            .o_empty   (w_empty[g]),
            .o_full    (w_full[g]),
            .o_level   (out_queue_level[slice_lo(g, LVL_W) +: LVL_W])
        );

        assign m_axis_tdata[slice_lo(g, DW) +: DW] = w_head[g][ENT_W-1 -: DW];
        assign m_axis_tuser[slice_lo(g, UW) +: UW] = w_head[g][UW-1:0];
    end

endmodule

// File: tb/tb_output_action_demux.sv
// Directed + randomized bench for output_action_demux, checked against a queue-based reference model.
module tb_output_action_demux;

    localparam int CW    = 32;
    localparam int DW    = 64;
    localparam int UW    = 16;
    localparam int NQ    = 5;
    localparam int DB    = 4;
    localparam int DEPTH = 16;
    localparam int LW    = DB + 1;

    typedef logic [DW+UW-1:0] ent_t;

    logic                 axi_aclk = 1'b0;
    logic                 axi_resetn;
    logic [DW-1:0]        s_tdata;
    logic [UW-1:0]        s_tuser;
    logic                 s_tvalid;
    logic                 s_tready;
    logic [NQ*DW-1:0]     m_tdata;
    logic [NQ*UW-1:0]     m_tuser;
    logic [NQ-1:0]        m_tvalid;
    logic [NQ-1:0]        m_tready;
    logic [CW-1:0]        arb_cnt;
    logic [CW-1:0]        rd_cnt;
    logic [CW-1:0]        drop_cnt;
    logic [NQ*LW-1:0]     q_level;

    ent_t          mq [NQ][$];
    logic [CW-1:0] m_arb;
    logic [CW-1:0] m_rd;
    logic [CW-1:0] m_drop;
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;

    always #5 axi_aclk = ~axi_aclk;

    output_action_demux #(
        .C_S_AXI_DATA_WIDTH (CW),
        .C_ACT_TDATA_WIDTH  (DW),
        .C_ACT_TUSER_WIDTH  (UW),
        .NUM_QUEUES         (NQ),
        .DEPTH_BITS         (DB)
    ) dut (
        .axi_aclk           (axi_aclk),
        .axi_resetn         (axi_resetn),
        .s_axis_tdata       (s_tdata),
        .s_axis_tuser       (s_tuser),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tready      (s_tready),
        .m_axis_tdata       (m_tdata),
        .m_axis_tuser       (m_tuser),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .out_arb_counter    (arb_cnt),
        .out_arb_rd_counter (rd_cnt),
        .out_drop_counter   (drop_cnt),
        .out_queue_level    (q_level)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NQ-1:0] model_full();
        logic [NQ-1:0] f;
        for (int q = 0; q < NQ; q++) f[q] = (mq[q].size() == DEPTH);
        return f;
    endfunction

    task automatic model_clear();
        for (int q = 0; q < NQ; q++) mq[q].delete();
        m_arb  = '0;
        m_rd   = '0;
        m_drop = '0;
    endtask

    // Compare every DUT output against the model's current state.
    task automatic check_outputs(input string tag);
        logic [NQ-1:0] dest;
        logic          exp_rdy;
        dest = s_tuser[NQ-1:0];
`ifdef OUTPUT_ACTION_DROP_ON_FULL_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = ((dest & model_full()) == '0);
`endif
        chk({tag, ".tready"}, 512'(s_tready), 512'(exp_rdy));
        for (int q = 0; q < NQ; q++) begin
            chk($sformatf("%s.tvalid%0d", tag, q), 512'(m_tvalid[q]), 512'(mq[q].size() > 0));
            chk($sformatf("%s.level%0d", tag, q), 512'(q_level[q*LW +: LW]), 512'(mq[q].size()));
            if (mq[q].size() > 0) begin
                chk($sformatf("%s.head%0d", tag, q), 512'({m_tdata[q*DW +: DW], m_tuser[q*UW +: UW]}),
                    512'(mq[q][0]));
            end
        end
        chk({tag, ".arb_cnt"},  512'(arb_cnt),  512'(m_arb));
        chk({tag, ".rd_cnt"},   512'(rd_cnt),   512'(m_rd));
        chk({tag, ".drop_cnt"}, 512'(drop_cnt), 512'(m_drop));
    endtask

    // Advance the model by one clock edge from the currently driven inputs.
    task automatic model_step();
        logic [NQ-1:0] full_b;
        logic [NQ-1:0] dest;
        bit            acc;
        bit            any_pop;
        ent_t          tmp;
        full_b  = model_full();
        dest    = s_tuser[NQ-1:0];
        any_pop = 0;
`ifdef OUTPUT_ACTION_DROP_ON_FULL_EN
        acc = s_tvalid;
        if (s_tvalid && ((dest & full_b) != '0)) m_drop++;
`else
        acc = s_tvalid && ((dest & full_b) == '0);
`endif
        for (int q = 0; q < NQ; q++) begin
            if (mq[q].size() > 0 && m_tready[q]) begin
                tmp = mq[q].pop_front();
                any_pop = 1;
            end
        end
        if (acc && dest != '0) begin
            m_arb++;
            for (int q = 0; q < NQ; q++)
                if (dest[q] && !full_b[q]) mq[q].push_back({s_tdata, s_tuser});
        end
        if (any_pop) m_rd++;
    endtask

    task automatic cyc(input string tag, input logic v, input logic [UW-1:0] u,
                       input logic [DW-1:0] d, input logic [NQ-1:0] rdy);
        s_tvalid = v;
        s_tuser  = u;
        s_tdata  = d;
        m_tready = rdy;
        @(negedge axi_aclk);
        check_outputs(tag);
        model_step();
        @(posedge axi_aclk);
        #1;
    endtask

    function automatic logic [UW-1:0] mk_user(input logic [NQ-1:0] dest);
        logic [UW-1:0] u;
        u = UW'($urandom());
        u[NQ-1:0] = dest;
        return u;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        axi_resetn = 1'b0;
        s_tvalid   = 1'b0;
        s_tuser    = '0;
        s_tdata    = '0;
        m_tready   = '0;
        model_clear();
        #12;
        check_outputs("reset");
        @(negedge axi_aclk);
        #2 axi_resetn = 1'b1;
        @(posedge axi_aclk);
        #1;

        // Unicast to queue 2, visible the following cycle.
        cyc("t1.send", 1'b1, mk_user(5'b00100), {8{8'hA5}}, 5'b11111);
        cyc("t1.out", 1'b0, '0, '0, 5'b00000);
        chk("t1.q2_data", 512'(m_tdata[2*DW +: DW]), 512'({8{8'hA5}}));
        cyc("t1.drain", 1'b0, '0, '0, 5'b11111);

        // Multicast with queue 1 stalled until it fills and backpressures.
        for (int i = 0; i < 18; i++) cyc($sformatf("t2.b%0d", i), 1'b1, mk_user(5'b10011), rnd_data(), 5'b11101);
        chk("t2.q1_full_tready", 512'(s_tready), 512'(1'b0));

        // Isolation: other queue still accepts; then one pop on q1 frees a slot.
        cyc("t3.q0", 1'b1, mk_user(5'b00001), rnd_data(), 5'b11101);
        cyc("t3.pop1", 1'b0, '0, '0, 5'b00010);
        cyc("t3.q1", 1'b1, mk_user(5'b00010), rnd_data(), 5'b11101);
        cyc("t3.chk", 1'b0, mk_user(5'b00010), '0, 5'b11101);
        for (int i = 0; i < 20; i++) cyc("t3.drain", 1'b0, '0, '0, 5'b11111);

        // Null bitmap beats are swallowed silently.
        for (int i = 0; i < 10; i++) cyc($sformatf("t4.b%0d", i), 1'b1, mk_user(5'b00000), rnd_data(), 5'b11111);
        cyc("t4.after", 1'b0, '0, '0, 5'b11111);

`ifdef OUTPUT_ACTION_DROP_ON_FULL_EN
        for (int i = 0; i < DEPTH; i++) cyc("t5.fill", 1'b1, mk_user(5'b01000), rnd_data(), 5'b00000);
        cyc("t5.mc", 1'b1, mk_user(5'b01001), rnd_data(), 5'b00000);
        cyc("t5.chk", 1'b0, '0, '0, 5'b00000);
        chk("t5.drop", 512'(drop_cnt), 512'(m_drop));
        for (int i = 0; i < 20; i++) cyc("t5.drain", 1'b0, '0, '0, 5'b11111);
`endif

        // Randomized traffic with varying output readiness.
        for (int i = 0; i < 600; i++) begin
            logic [NQ-1:0] rdy;
            int thr;
            thr = (i < 200) ? 3 : ((i < 400) ? 9 : 6);
            for (int q = 0; q < NQ; q++) rdy[q] = ($urandom_range(0, 9) < thr);
            cyc($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0), mk_user(NQ'($urandom())), rnd_data(), rdy);
        end

        // Mid-burst reset: build up occupancy then drop reset between edges.
        for (int i = 0; i < 8; i++) cyc("t6.fill", 1'b1, mk_user(5'b11111), rnd_data(), 5'b00000);
        chk("t6.pre_level", 512'(q_level[0 +: LW] != '0), 512'(1'b1));
        @(negedge axi_aclk);
        #2 axi_resetn = 1'b0;
        s_tvalid = 1'b0;
        #1;
        model_clear();
        check_outputs("t6.reset");
        @(negedge axi_aclk);
        #2 axi_resetn = 1'b1;
        @(posedge axi_aclk);
        #1;
        cyc("t6.post", 1'b1, mk_user(5'b00001), rnd_data(), 5'b11111);
        cyc("t6.post2", 1'b0, '0, '0, 5'b11111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
